mpi_noc_packet_buffer: RTL and testbench



---
 rtl/mpi_noc_packet_buffer.sv | 99 +++++++++
 tb/tb_mpi_noc_packet_buffer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpi_noc_packet_buffer.sv
// Store-and-forward flit buffer for the MPI endpoint NoC egress path.
// Falls back to cut-through when a single packet cannot fit in the buffer.
module mpi_noc_packet_buffer #(
   parameter int NOC_FLIT_WIDTH = 32,
   parameter int DEPTH          = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NOC_FLIT_WIDTH-1:0]  in_flit,
   input  logic                       in_last,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [NOC_FLIT_WIDTH-1:0]  out_flit,
   output logic                       out_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] pkt_count,
   output logic                       cut_through
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic {STORE, CUT} state_t;

   logic [NOC_FLIT_WIDTH:0] mem_q [DEPTH];
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           fill_q, fill_d;
   logic [CW-1:0]           pkt_count_q, pkt_count_d;
   state_t                  state_q, state_d;

   logic full, empty, wr_en, rd_en, pkt_in, pkt_out;

   assign full        = (fill_q == DEPTH_C);
   assign empty       = (fill_q == '0);
   assign in_ready    = !full;
   assign cut_through = (state_q == CUT);
   assign pkt_count   = pkt_count_q;
   assign out_valid   = !empty && ((pkt_count_q != '0) || cut_through);
   assign {out_last, out_flit} = mem_q[rd_ptr_q];

   assign wr_en   = in_valid && in_ready;
   assign rd_en   = out_valid && out_ready;
   assign pkt_in  = wr_en && in_last;
   assign pkt_out = rd_en && out_last;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      fill_d      = fill_q;
      pkt_count_d = pkt_count_q;
      state_d     = state_q;

      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);

      case ({wr_en, rd_en})
         2'b10:   fill_d = fill_q + CW'(1);
         2'b01:   fill_d = fill_q - CW'(1);
         default: fill_d = fill_q;
      endcase

      case ({pkt_in, pkt_out})
         2'b10:   pkt_count_d = pkt_count_q + CW'(1);
         2'b01:   pkt_count_d = pkt_count_q - CW'(1);
         default: pkt_count_d = pkt_count_q;
      endcase

      // A full buffer with no complete packet can never finish storing, so stream it.
      case (state_q)
         STORE:   if (full && (pkt_count_q == '0)) state_d = CUT;
         CUT:     if (pkt_out) state_d = STORE;
         default: state_d = STORE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fill_q      <= '0;
         pkt_count_q <= '0;
         state_q     <= STORE;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fill_q      <= fill_d;
         pkt_count_q <= pkt_count_d;
         state_q     <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= {in_last, in_flit};
   end

endmodule

// File: tb/tb_mpi_noc_packet_buffer.sv
// Scoreboard testbench for mpi_noc_packet_buffer: driver pushes accepted flits,
// a negedge monitor checks handshake/counters against a small model and pops data.
module tb_mpi_noc_packet_buffer;

   localparam int W     = 32;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  in_flit;
   logic          in_last;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  out_flit;
   logic          out_last;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] pkt_count;
   logic          cut_through;

   int total = 0;
   int bad   = 0;

   logic [W:0] sbq[$];

   int         mFill = 0;
   int         mPkt  = 0;
   bit         mCut  = 1'b0;
   bit         monExpValid, monExpReady, monRd, monWr, monFrontLast;
   logic [W:0] monFront;

   mpi_noc_packet_buffer #(.NOC_FLIT_WIDTH(W), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_flit     (in_flit),
      .in_last     (in_last),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_flit    (out_flit),
      .out_last    (out_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .pkt_count   (pkt_count),
      .cut_through (cut_through)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic reportTimeout(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: timed out waiting, expected completion at %0t", name, $time);
   endtask

   // Offer one flit until accepted; expOv >= 0 also checks out_valid on the accepting cycle.
   task automatic applyStimulus(input logic [W-1:0] flit, input logic last, input bit rnd, input int expOv);
      bit accepted = 1'b0;
      int cycles   = 0;
      in_flit = flit;
      in_last = last;
      while (!accepted && cycles < 2000) begin
         if (rnd) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 1) == 1);
         end else begin
            in_valid = 1'b1;
         end
         @(negedge clk);
         if (in_valid && in_ready) begin
            accepted = 1'b1;
            sbq.push_back({last, flit});
            if (expOv >= 0) checkOutput("accept_out_valid", W'(out_valid), W'(expOv));
         end
         @(posedge clk);
         #1;
         cycles++;
      end
      in_valid = 1'b0;
      if (!accepted) reportTimeout("write_accept");
   endtask

   task automatic waitDrain();
      int cycles = 0;
      while (sbq.size() != 0 && cycles < 2000) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      if (sbq.size() != 0) reportTimeout("drain");
   endtask

   // Monitor: checks every cycle against the model, compares the presented flit with the queue head.
   always @(negedge clk) begin
      if (rst) begin
         mFill = 0;
         mPkt  = 0;
         mCut  = 1'b0;
         sbq.delete();
      end else begin
         monExpReady  = (mFill != DEPTH);
         monExpValid  = (mFill != 0) && ((mPkt != 0) || mCut);
         checkOutput("in_ready", W'(in_ready), W'(monExpReady));
         checkOutput("out_valid", W'(out_valid), W'(monExpValid));
         checkOutput("pkt_count", W'(pkt_count), W'(mPkt));
         checkOutput("cut_through", W'(cut_through), W'(mCut));
         monRd        = 1'b0;
         monFrontLast = 1'b0;
         if (monExpValid) begin
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL scoreboard_empty: out_valid with no expected flit at %0t", $time);
            end else begin
               monFront     = sbq[0];
               monFrontLast = monFront[W];
               checkOutput("out_flit", out_flit, monFront[W-1:0]);
               checkOutput("out_last", W'(out_last), W'(monFront[W]));
               if (out_ready) begin
                  monRd = 1'b1;
                  void'(sbq.pop_front());
               end
            end
         end
         monWr = in_valid && monExpReady;
         if (!mCut && mFill == DEPTH && mPkt == 0) mCut = 1'b1;
         else if (mCut && monRd && monFrontLast) mCut = 1'b0;
         mFill = mFill + int'(monWr) - int'(monRd);
         mPkt  = mPkt + int'(monWr && in_last) - int'(monRd && monFrontLast);
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected end before %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int len;
      rst       = 1'b1;
      in_flit   = '0;
      in_last   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_in_ready", W'(in_ready), 32'd1);
      checkOutput("reset_out_valid", W'(out_valid), 32'd0);
      checkOutput("reset_pkt_count", W'(pkt_count), 32'd0);
      checkOutput("reset_cut", W'(cut_through), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] single-flit packet");
      out_ready = 1'b1;
      applyStimulus(32'hA5A5_0001, 1'b1, 1'b0, 0);
      @(negedge clk);
      checkOutput("single_out_valid", W'(out_valid), 32'd1);
      checkOutput("single_out_flit", out_flit, 32'hA5A5_0001);
      checkOutput("single_out_last", W'(out_last), 32'd1);
      checkOutput("single_pkt_count", W'(pkt_count), 32'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("single_pkt_after", W'(pkt_count), 32'd0);
      checkOutput("single_valid_after", W'(out_valid), 32'd0);
      @(posedge clk);
      #1;

      $display("[TB] four-flit packet");
      for (int i = 0; i < 4; i++) applyStimulus(32'h10 + i, (i == 3), 1'b0, 0);
      @(negedge clk);
      checkOutput("four_out_valid", W'(out_valid), 32'd1);
      checkOutput("four_first_flit", out_flit, 32'h10);
      @(posedge clk);
      #1;
      waitDrain();

      $display("[TB] oversize packet");
      for (int i = 0; i < 16; i++) applyStimulus(32'h3000_0000 + i, 1'b0, 1'b0, 0);
      @(negedge clk);
      checkOutput("over_in_ready_full", W'(in_ready), 32'd0);
      checkOutput("over_cut_before", W'(cut_through), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("over_cut_active", W'(cut_through), 32'd1);
      checkOutput("over_out_valid", W'(out_valid), 32'd1);
      checkOutput("over_first_flit", out_flit, 32'h3000_0000);
      @(posedge clk);
      #1;
      for (int i = 16; i < 20; i++) applyStimulus(32'h3000_0000 + i, (i == 19), 1'b0, -1);
      waitDrain();
      @(negedge clk);
      checkOutput("over_cut_cleared", W'(cut_through), 32'd0);
      checkOutput("over_empty", W'(out_valid), 32'd0);
      @(posedge clk);
      #1;

      $display("[TB] full of single-flit packets");
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) applyStimulus(32'h100 + i, 1'b1, 1'b0, -1);
      @(negedge clk);
      checkOutput("full_in_ready", W'(in_ready), 32'd0);
      checkOutput("full_pkt_count", W'(pkt_count), 32'd16);
      checkOutput("full_cut", W'(cut_through), 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) applyStimulus(32'h200 + i, 1'b1, 1'b0, 1);
      waitDrain();

      $display("[TB] random traffic");
      for (int p = 0; p < 200; p++) begin
         len = $urandom_range(1, 8);
         for (int f = 0; f < len; f++) applyStimulus({16'(p), 16'(f)}, (f == len - 1), 1'b1, -1);
      end
      out_ready = 1'b1;
      waitDrain();

      $display("[TB] reset mid-packet");
      out_ready = 1'b0;
      applyStimulus(32'h0000_C0DE, 1'b1, 1'b0, -1);
      applyStimulus(32'h0000_0A01, 1'b0, 1'b0, -1);
      applyStimulus(32'h0000_0A02, 1'b0, 1'b0, -1);
      rst = 1'b1;
      #1;
      checkOutput("rst_out_valid", W'(out_valid), 32'd0);
      checkOutput("rst_pkt_count", W'(pkt_count), 32'd0);
      checkOutput("rst_in_ready", W'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      applyStimulus(32'h0000_BEEF, 1'b1, 1'b0, 0);
      @(negedge clk);
      checkOutput("post_rst_flit", out_flit, 32'h0000_BEEF);
      checkOutput("post_rst_pkt", W'(pkt_count), 32'd1);
      @(posedge clk);
      #1;
      waitDrain();
      @(negedge clk);
      checkOutput("post_rst_alone", W'(out_valid), 32'd0);
      @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
